// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, Status bit positions, default vector,
// and helpers that pack the architectural read-back words.
package cp0_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int IM_LO      = 8;
  localparam int IM_HI      = 15;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

  // Status read-back: IM in [15:8], EXL in bit 1, IE in bit 0, all else zero.
  function automatic logic [31:0] status_word(input logic [7:0] im,
                                              input logic       exl,
                                              input logic       ie);
    return {16'b0, im, 6'b0, exl, ie};
  endfunction

  // Cause read-back: only IP[15:8] is implemented.
  function automatic logic [31:0] cause_word(input logic [7:0] ip);
    return {16'b0, ip, 8'b0};
  endfunction

endpackage

// File: rtl/cp0_pending.sv
// Pending-interrupt tracking: samples the timer and external lines into IP every
// cycle, masks with IM and reduces to the "take an interrupt now" request.
module cp0_pending #(
  parameter int NUM_EXT = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               timer_i,
  input  logic [NUM_EXT-1:0] ext_irq_i,
  input  logic [7:0]         im_i,
  input  logic               ie_i,
  input  logic               exl_i,
  output logic [7:0]         ip_o,
  output logic               taken_o
);

  logic [7:0] ip_d;
  logic [7:0] ip_q;

  // Map sources onto IP positions; unmapped positions stay zero.
  always_comb begin
    ip_d                = '0;
    ip_d[NUM_EXT-1:0]   = ext_irq_i;
    ip_d[7]             = timer_i;
  end

  // IP is level-tracking: it follows the sources with one cycle of latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ip_q <= '0;
    end else begin
      ip_q <= ip_d;
    end
  end

  assign ip_o = ip_q;

  // Request only from registered state, so no pin-to-output combinational path.
  assign taken_o = (|(ip_q & im_i)) & ie_i & ~exl_i;

endmodule

// File: rtl/register.sv
// Generic enable register with asynchronous active-high clear.
module register #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled; clear to zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cp0_interrupt_unit.sv
// Coprocessor-0 interrupt unit: Status/Cause/EPC, mfc0/mtc0/eret servicing,
// and the TakenInterrupt request used to redirect fetch to the exception vector.
module cp0_interrupt_unit
  import cp0_pkg::*;
#(
  parameter int          NUM_EXT    = 7,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               TimerInterrupt,
  input  logic [NUM_EXT-1:0] ext_irq,
  input  logic               MTC0,
  input  logic               ERET,
  input  logic [4:0]         regnum,
  input  logic [31:0]        wr_data,
  input  logic [31:0]        next_pc,
  output logic [31:0]        rd_data,
  output logic [31:0]        EPC,
  output logic [31:0]        exc_vector,
  output logic               TakenInterrupt
);

  // Status storage packed as {IM[7:0], EXL, IE}; low two bits line up with
  // STATUS_EXL / STATUS_IE.
  logic [9:0]  status_q;
  logic [9:0]  status_d;
  logic        status_en;
  logic [31:0] epc_q;
  logic [31:0] epc_d;
  logic        epc_en;
  logic [7:0]  ip;
  logic        taken;
  logic        wr_status;
  logic        wr_epc;
  logic        unused_wr_bits;

  assign unused_wr_bits = ^{wr_data[31:16], wr_data[7:2]};

  register #(.W(10)) u_status (
    .clk (clock),
    .rst (reset),
    .en  (status_en),
    .d   (status_d),
    .q   (status_q)
  );

  register #(.W(32)) u_epc (
    .clk (clock),
    .rst (reset),
    .en  (epc_en),
    .d   (epc_d),
    .q   (epc_q)
  );

  cp0_pending #(.NUM_EXT(NUM_EXT)) u_pending (
    .clock     (clock),
    .reset     (reset),
    .timer_i   (TimerInterrupt),
    .ext_irq_i (ext_irq),
    .im_i      (status_q[9:2]),
    .ie_i      (status_q[STATUS_IE]),
    .exl_i     (status_q[STATUS_EXL]),
    .ip_o      (ip),
    .taken_o   (taken)
  );

  assign wr_status = MTC0 && (regnum == CP0_STATUS);
  assign wr_epc    = MTC0 && (regnum == CP0_EPC);

  // Next-state for Status/EPC: a taken interrupt squashes the instruction in
  // execute; otherwise eret clears EXL (overriding a same-cycle Status write).
  always_comb begin
    status_d = status_q;
    epc_d    = epc_q;
    if (taken) begin
      status_d[STATUS_EXL] = 1'b1;
      epc_d                = next_pc;
    end else begin
      if (wr_status) begin
        status_d = {wr_data[IM_HI:IM_LO], wr_data[STATUS_EXL], wr_data[STATUS_IE]};
      end
      if (ERET) begin
        status_d[STATUS_EXL] = 1'b0;
      end
      if (wr_epc) begin
        epc_d = wr_data;
      end
    end
    status_en = taken | ERET | wr_status;
    epc_en    = taken | wr_epc;
  end

  // mfc0 read mux on pre-edge state; Cause writes are never stored.
  always_comb begin
    rd_data = 32'b0;
    case (regnum)
      CP0_STATUS: rd_data = status_word(status_q[9:2], status_q[STATUS_EXL],
                                        status_q[STATUS_IE]);
      CP0_CAUSE:  rd_data = cause_word(ip);
      CP0_EPC:    rd_data = epc_q;
      default:    rd_data = 32'b0;
    endcase
  end

  assign EPC            = epc_q;
  assign exc_vector     = EXC_VECTOR;
  assign TakenInterrupt = taken;

endmodule

// File: tb/tb_cp0_interrupt_unit.sv
// Scoreboard bench for cp0_interrupt_unit: expectations are queued as stimulus
// is applied and popped when the outputs are sampled.
module tb_cp0_interrupt_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        TimerInterrupt;
  logic [6:0]  ext_irq;
  logic        MTC0;
  logic        ERET;
  logic [4:0]  regnum;
  logic [31:0] wr_data;
  logic [31:0] next_pc;
  logic [31:0] rd_data;
  logic [31:0] EPC;
  logic [31:0] exc_vector;
  logic        TakenInterrupt;

  int errors = 0;
  int checks = 0;

  string       tag_q[$];
  int          kind_q[$];
  logic [31:0] val_q[$];

  localparam int K_RD    = 0;
  localparam int K_TAKEN = 1;
  localparam int K_EPC   = 2;
  localparam int K_VEC   = 3;

  always #5 clock = ~clock;

  cp0_interrupt_unit #(.NUM_EXT(7), .EXC_VECTOR(32'h8000_0180)) dut (
    .clock          (clock),
    .reset          (reset),
    .TimerInterrupt (TimerInterrupt),
    .ext_irq        (ext_irq),
    .MTC0           (MTC0),
    .ERET           (ERET),
    .regnum         (regnum),
    .wr_data        (wr_data),
    .next_pc        (next_pc),
    .rd_data        (rd_data),
    .EPC            (EPC),
    .exc_vector     (exc_vector),
    .TakenInterrupt (TakenInterrupt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int kind, input logic [31:0] v);
    tag_q.push_back(tag);
    kind_q.push_back(kind);
    val_q.push_back(v);
  endtask

  // Let combinational outputs settle, then drain the scoreboard.
  task automatic observe();
    string       t;
    int          k;
    logic [31:0] v;
    logic [31:0] obs;
    #1;
    while (tag_q.size() > 0) begin
      t = tag_q.pop_front();
      k = kind_q.pop_front();
      v = val_q.pop_front();
      case (k)
        K_RD:    obs = rd_data;
        K_TAKEN: obs = {31'b0, TakenInterrupt};
        K_EPC:   obs = EPC;
        default: obs = exc_vector;
      endcase
      chk(t, obs, v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [4:0] r, input logic [31:0] exp, input string tag);
    regnum = r;
    push_exp(tag, K_RD, exp);
    observe();
  endtask

  task automatic taken_is(input logic exp, input string tag);
    push_exp(tag, K_TAKEN, {31'b0, exp});
    observe();
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    MTC0    = 1'b1;
    regnum  = r;
    wr_data = d;
    tick();
    MTC0    = 1'b0;
    wr_data = 32'h0;
  endtask

  initial begin
    reset          = 1'b1;
    TimerInterrupt = 1'b0;
    ext_irq        = '0;
    MTC0           = 1'b0;
    ERET           = 1'b0;
    regnum         = 5'd0;
    wr_data        = 32'h0;
    next_pc        = 32'h0;
    tick();
    tick();
    reset = 1'b0;

    // Post-reset state
    push_exp("vector", K_VEC, 32'h8000_0180);
    push_exp("rst_epc", K_EPC, 32'h0);
    push_exp("rst_taken", K_TAKEN, 32'h0);
    observe();
    rd(5'd12, 32'h0, "rst_status");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc_rd");
    tick();

    // Timer interrupt taken one cycle after the source rises
    mtc0(5'd12, 32'h0000_8001);
    rd(5'd12, 32'h0000_8001, "status_wr");
    TimerInterrupt = 1'b1;
    taken_is(1'b0, "ip_latency");
    tick();
    TimerInterrupt = 1'b0;
    next_pc        = 32'h0040_0020;
    taken_is(1'b1, "timer_take");
    rd(5'd13, 32'h0000_8000, "cause_timer");
    tick();
    push_exp("epc_after_take", K_EPC, 32'h0040_0020);
    taken_is(1'b0, "exl_blocks");
    rd(5'd12, 32'h0000_8003, "exl_set");

    // eret with timer still pending -> retaken next cycle
    TimerInterrupt = 1'b1;
    tick();
    taken_is(1'b0, "nested_held");
    rd(5'd13, 32'h0000_8000, "nested_ip");
    ERET = 1'b1;
    taken_is(1'b0, "eret_cycle");
    tick();
    ERET = 1'b0;
    rd(5'd12, 32'h0000_8001, "eret_clr_exl");
    push_exp("eret_epc_keep", K_EPC, 32'h0040_0020);
    taken_is(1'b1, "retake_after_eret");
    next_pc = 32'h0040_0040;
    tick();
    push_exp("epc_retake", K_EPC, 32'h0040_0040);
    observe();

    // eret after the source drops -> no retake
    TimerInterrupt = 1'b0;
    tick();
    ERET = 1'b1;
    tick();
    ERET = 1'b0;
    taken_is(1'b0, "no_retake");
    rd(5'd12, 32'h0000_8001, "eret2_status");
    tick();
    taken_is(1'b0, "no_retake2");

    // Taken interrupt squashes same-cycle mtc0 $14 and eret
    TimerInterrupt = 1'b1;
    tick();
    MTC0    = 1'b1;
    regnum  = 5'd14;
    wr_data = 32'hdead_beef;
    ERET    = 1'b1;
    next_pc = 32'h0040_0100;
    taken_is(1'b1, "take_vs_mtc0");
    tick();
    MTC0 = 1'b0;
    ERET = 1'b0;
    push_exp("epc_not_deadbeef", K_EPC, 32'h0040_0100);
    observe();
    rd(5'd12, 32'h0000_8003, "eret_squashed");
    TimerInterrupt = 1'b0;
    tick();

    // IM selects ext_irq[0] only
    mtc0(5'd12, 32'h0000_0101);
    rd(5'd12, 32'h0000_0101, "im_ext0");
    TimerInterrupt = 1'b1;
    tick();
    taken_is(1'b0, "timer_masked");
    rd(5'd13, 32'h0000_8000, "cause_masked");
    ext_irq[0] = 1'b1;
    next_pc    = 32'h0040_0200;
    tick();
    taken_is(1'b1, "ext0_take");
    rd(5'd13, 32'h0000_8100, "cause_ext0");
    ext_irq        = '0;
    TimerInterrupt = 1'b0;
    tick();
    push_exp("epc_ext0", K_EPC, 32'h0040_0200);
    observe();
    rd(5'd12, 32'h0000_0103, "exl_ext0");

    // Upper external line lands in IP[14]
    ext_irq[6] = 1'b1;
    tick();
    rd(5'd13, 32'h0000_4000, "cause_ext6");
    ext_irq = '0;
    tick();

    // mtc0 $12 with EXL=1 together with eret: eret wins on EXL
    MTC0    = 1'b1;
    regnum  = 5'd12;
    wr_data = 32'h0000_0003;
    ERET    = 1'b1;
    tick();
    MTC0 = 1'b0;
    ERET = 1'b0;
    rd(5'd12, 32'h0000_0001, "eret_wins_exl");
    mtc0(5'd14, 32'h1234_5678);
    rd(5'd14, 32'h1234_5678, "mtc0_epc");

    // Cause is read-only; unmapped regnums read zero and ignore writes
    mtc0(5'd13, 32'hffff_ffff);
    rd(5'd13, 32'h0, "cause_ro");
    mtc0(5'd20, 32'hffff_ffff);
    rd(5'd20, 32'h0, "reg20");
    rd(5'd12, 32'h0000_0001, "reg20_no_effect");

    // Asynchronous reset mid-run
    reset = 1'b1;
    push_exp("async_epc", K_EPC, 32'h0);
    observe();
    rd(5'd12, 32'h0, "async_status");
    tick();
    reset = 1'b0;
    rd(5'd12, 32'h0, "mid_rst_status");
    rd(5'd13, 32'h0, "mid_rst_cause");
    rd(5'd14, 32'h0, "mid_rst_epc");
    taken_is(1'b0, "mid_rst_taken");
    TimerInterrupt = 1'b1;
    ext_irq        = 7'h7f;
    tick();
    taken_is(1'b0, "ie_off_after_rst");
    rd(5'd13, 32'h0000_ff00, "cause_all");
    TimerInterrupt = 1'b0;
    ext_irq        = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
